// File: rtl/seg_capture7.sv
// seg_capture7: samples a multiplexed seven-segment bus, debounces each
// digit's pattern, decodes it back to ASCII and streams changed digits.
//
// Parameters:
//   DIGITS     number of multiplexed digits (2..8)
//   STABLE     identical consecutive samples needed to accept (1..15)
// Ports:
//   clk        sole clock
//   reset      asynchronous active-high reset
//   an         digit enables, active-high, one-hot or zero
//   seg        segment lines, bit6=a .. bit0=g, active-high
//   text       decoded text shadow, byte i = digit i
//   out_valid  event available
//   out_ready  consumer accepts event
//   out_idx    digit index of presented event
//   out_char   ASCII character of presented event
//   err_count  saturating count of illegal (multi-hot) enable samples
// Build option:
//   SEG_CAPTURE_ERR_EN  when defined, err_count is implemented;
//                       otherwise it is tied to zero.

module seg_capture7 #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGITS-1:0]   an,
    input  logic [6:0]          seg,
    output logic [8*DIGITS-1:0] text,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_idx,
    output logic [7:0]          out_char,
    output logic [7:0]          err_count
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [3:0] STABLE_C = 4'(STABLE);
    localparam logic [DIGITS-1:0] AN_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    // Input sample stage and the previous sample for comparison
    logic [DIGITS-1:0] s_an_q;
    logic [6:0]        s_seg_q;
    logic [DIGITS-1:0] p_an_q;
    logic [6:0]        p_seg_q;

    // Stability FSM
    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;

    // Text shadow and pending-event flags
    logic [7:0]        text_q [DIGITS];
    logic [DIGITS-1:0] dirty_q, dirty_d;

    // Output register
    logic          valid_q, valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    char_q, char_d;

    // Segment pattern -> ASCII
    function automatic logic [7:0] decode7(input logic [6:0] p);
        logic [7:0] c;
        case (p)
            7'b1111110: c = 8'h30;
            7'b0110000: c = 8'h31;
            7'b1101101: c = 8'h32;
            7'b1111001: c = 8'h33;
            7'b0110011: c = 8'h34;
            7'b1011011: c = 8'h35;
            7'b1011111: c = 8'h36;
            7'b1110000: c = 8'h37;
            7'b1111111: c = 8'h38;
            7'b1111011: c = 8'h39;
            7'b1110111: c = 8'h41;
            7'b1001110: c = 8'h43;
            7'b1001111: c = 8'h45;
            7'b1000111: c = 8'h46;
            7'b0110111: c = 8'h48;
            7'b0111000: c = 8'h4A;
            7'b0001110: c = 8'h4C;
            7'b1100111: c = 8'h50;
            7'b0111110: c = 8'h55;
            7'b0111011: c = 8'h59;
            7'b0011111: c = 8'h62;
            7'b0001101: c = 8'h63;
            7'b0111101: c = 8'h64;
            7'b0010111: c = 8'h68;
            7'b0011101: c = 8'h6F;
            7'b0011100: c = 8'h75;
            7'b0000001: c = 8'h2D;
            7'b0000000: c = 8'h20;
            default:    c = 8'h3F;
        endcase
        return c;
    endfunction

    // Sample classification
    logic          s_nonzero;
    logic          s_onehot;
    logic          s_same;
    logic [IW-1:0] s_idx;

    assign s_nonzero = (s_an_q != '0);
    assign s_onehot  = s_nonzero &&
                       ((s_an_q & (s_an_q - AN_ONE)) == '0);
    assign s_same    = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);

    always_comb begin
        s_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s_an_q[i]) begin
                s_idx = IW'(i);
            end
        end
    end

    // Stability FSM: accept pulses only on the edge that enters LOCK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!s_onehot) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == ST_IDLE || !s_same) begin
            cnt_d = 4'd1;
            if (STABLE_C == 4'd1) begin
                state_d = ST_LOCK;
                accept  = 1'b1;
            end else begin
                state_d = ST_TRACK;
            end
        end else if (state_q == ST_TRACK) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == STABLE_C) begin
                state_d = ST_LOCK;
                accept  = 1'b1;
            end
        end
    end

    // Accept: only a changed character writes the shadow
    logic [7:0] dec_char;
    logic       wr;

    assign dec_char = decode7(s_seg_q);
    assign wr       = accept && (dec_char != text_q[s_idx]);

    // Arbiter: lowest-index dirty digit first
    logic          any_dirty;
    logic [IW-1:0] d_idx;
    logic          load;

    always_comb begin
        any_dirty = 1'b0;
        d_idx     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (dirty_q[i]) begin
                any_dirty = 1'b1;
                d_idx     = IW'(i);
            end
        end
    end

    assign load = !valid_q && any_dirty;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        char_d  = char_q;
        if (load) begin
            valid_d = 1'b1;
            idx_d   = d_idx;
            char_d  = text_q[d_idx];
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // A set from an accept on the same edge overrides the load's clear
    always_comb begin
        dirty_d = dirty_q;
        if (load) begin
            dirty_d[d_idx] = 1'b0;
        end
        if (wr) begin
            dirty_d[s_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_an_q  <= '0;
            s_seg_q <= '0;
            p_an_q  <= '0;
            p_seg_q <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dirty_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            char_q  <= 8'h20;
            for (int i = 0; i < DIGITS; i++) begin
                text_q[i] <= 8'h20;
            end
        end else begin
            s_an_q  <= an;
            s_seg_q <= seg;
            p_an_q  <= s_an_q;
            p_seg_q <= s_seg_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            if (wr) begin
                text_q[s_idx] <= dec_char;
            end
        end
    end

`ifdef SEG_CAPTURE_ERR_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if (s_nonzero && !s_onehot && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_text
        assign text[8*g +: 8] = text_q[g];
    end

    assign out_valid = valid_q;
    assign out_idx   = 3'(idx_q);
    assign out_char  = char_q;

endmodule

// File: doc/seg_capture7.md
# seg_capture7

Reverse of the character-to-segment lookup. Samples a multiplexed seven-segment display bus (one-hot digit enables plus seven segment lines), debounces each digit's pattern and decodes it back to an ASCII character. It keeps a per-digit text shadow and reports each changed digit over a valid/ready stream. It sits between the display driver pins and a readout or self-check path.

## Interface
- `DIGITS`, 4: number of multiplexed digits, 2..8.
- `STABLE`, 3: consecutive identical samples required to accept a pattern, 1..15.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `an` in DIGITS: digit enables, active-high, expected one-hot or zero.
- `seg` in 7: segment lines, bit6=a … bit0=g, active-high.
- `text` out 8*DIGITS: decoded shadow; byte i = digit i.
- `out_valid` out 1: event available.
- `out_ready` in 1: consumer accepts.
- `out_idx` out 3: digit index of event.
- `out_char` out 8: ASCII of event.
- `err_count` out 8: illegal-enable counter, saturating (see Configuration).

## Operation
- Input stage: `an`/`seg` registered once per edge into `s_an`/`s_seg`.
- Stability FSM:
  - IDLE: `s_an` zero or not one-hot. Counter cleared.
  - TRACK: `s_an` one-hot. Counter increments while (`s_an`, `s_seg`) equals previous sample; any change reloads counter to 1 and stays in TRACK (or goes to IDLE).
  - LOCK: entered when counter reaches STABLE. Accept fires exactly once on entry. Remain in LOCK until the sample changes, then TRACK/IDLE as above.
- Accept: decode `s_seg`. If result differs from `text[idx]`, write `text[idx]` and set `dirty[idx]`. If equal, no event.
- Decode, canonical on aliasing:
  - Digits: 1111110 '0', 0110000 '1', 1101101 '2', 1111001 '3', 0110011 '4', 1011011 '5', 1011111 '6', 1110000 '7', 1111111 '8', 1111011 '9'.
  - Uppercase: 1110111 'A', 1001110 'C', 1001111 'E', 1000111 'F', 0110111 'H', 0111000 'J', 0001110 'L', 1100111 'P', 0111110 'U', 0111011 'Y'.
  - Lowercase: 0011111 'b', 0001101 'c', 0111101 'd', 0010111 'h', 0011101 'o', 0011100 'u'.
  - Other: 0000001 '-', 0000000 ' ' (0x20).
  - Anything else: '?' (0x3F).
- Output arbiter: when `out_valid`=0 and any `dirty` bit is set, load lowest-index dirty digit into `out_idx`/`out_char`, clear that dirty bit, and assert `out_valid`.
- Handshake:
  - `out_idx`/`out_char` are held stable while `out_valid`=1.
  - Transfer happens on an edge with `out_valid & out_ready`; `out_valid` drops on that edge.
  - The next load happens no earlier than the following edge.
- Coalescing: repeated changes to an un-dispatched digit produce one event carrying the latest `text` value.
- Simultaneous events:
  - An accept to the digit being loaded on the same edge: the arbiter loads the old `text` value, and `dirty` stays set (the set wins over the clear).
  - An accept to the digit currently presented: the presented value is unchanged and `dirty` is set, giving a later event.

## Timing
- Reset values: `text` all 0x20; `dirty` 0; `out_valid` 0; `out_idx` 0; `out_char` 0x20; `err_count` 0; FSM IDLE; counter 0; `s_an`/`s_seg` 0.
- Latency, with inputs constant before edge 1 and STABLE=S:
  - Samples are taken on edges 1..S.
  - Accept and `text` update occur on edge S+1.
  - `out_valid` rises on edge S+2 if the arbiter is idle.
- `reset` asserted mid-operation clears everything immediately, including a pending `out_valid`. No event survives reset.
- Throughput: at most one event per 2 edges.

## Configuration
- `SEG_CAPTURE_ERR_EN` defined: `err_count` increments once per sample cycle where `s_an` is nonzero and not one-hot. It saturates at 255.
- `SEG_CAPTURE_ERR_EN` not defined: `err_count` is tied to 0 and its logic is omitted. Illegal enables still behave as IDLE.

## Test plan
- Reset, then idle inputs → `text`=0x20202020, `out_valid`=0, `err_count`=0.
- STABLE=3, `an`=0001, `seg`=1101101 held → `text[7:0]`=0x32 after edge 4; `out_valid`=1 with `out_idx`=0, `out_char`=0x32 after edge 5; `out_ready`=1 → `out_valid` drops next edge; holding further produces no second event.
- `seg` toggles between two patterns every 2 cycles on digit 1 → no accept, `text` unchanged, `out_valid` stays 0.
- `out_ready`=0; update digit 2 to 0110000, then 1111001 → exactly one event, `out_idx`=2, `out_char`=0x33 ('3'). Digits 0 and 3 updated together → events emitted in order idx 0 then 3.
- Pattern 1011111 → '6'; 0111011 → 'Y'; 1010101 → '?' (0x3F); 0000000 after '8' → event 0x20.
- `an`=0011 for 10 cycles → `err_count`=10 with `SEG_CAPTURE_ERR_EN`, 0 without; no text change. Reset asserted while `out_valid`=1 → all outputs return to reset values asynchronously.
